// File: rtl/io_bus_bridge.sv
// io_bus_bridge
//   Memory-stage bridge from the pipeline to the memory-mapped IO bus.
//   It aligns stores onto byte lanes and runs a req/ack transaction with the
//   peripheral, holding the pipeline while the transaction is open. Loads come
//   back sign- or zero-extended. Misaligned accesses are flagged at once and
//   never reach the bus.
//
//   Build option: define IO_TIMEOUT_EN to add the request timeout counter, the
//   FAULT state and the access-fault outputs. Without it, a request waits for
//   its ack indefinitely and the access-fault outputs are tied to 0.
//
//   Parameters
//     XLEN            width code: 1 = 32-bit, 2 = 64-bit (W = 1 << (XLEN+4))
//     TIMEOUT_CYCLES  REQ cycles without ack before a fault (used only with
//                     IO_TIMEOUT_EN)
//
//   Ports
//     i_clk, i_rst                  clock, synchronous active-high reset
//     i_io_en_m, i_lw_m, i_sw_m     M-stage IO hit and load/store strobes
//     i_funct3_m                    size/sign: 0 b,1 h,2 w,3 d,4 bu,5 hu,6 wu
//     i_addr_m, i_wdata_m           IO-relative offset, LSB-justified data
//     o_stall                       hold IF..M while the access is open
//     o_rdata, o_rdata_valid        extended load result and its strobe
//     o_misaligned_load/_store      combinational misalignment traps
//     o_access_fault_load/_store    one-cycle timeout traps
//     o_bus_*                       request, write flag, word address,
//                                   lane-shifted data, byte enables
//     i_bus_ack, i_bus_rdata        one-cycle completion and read data
module io_bus_bridge #(
  parameter int unsigned XLEN           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_io_en_m,
  input  logic                          i_lw_m,
  input  logic                          i_sw_m,
  input  logic [2:0]                    i_funct3_m,
  input  logic [(1<<(XLEN+4))-1:0]      i_addr_m,
  input  logic [(1<<(XLEN+4))-1:0]      i_wdata_m,
  output logic                          o_stall,
  output logic [(1<<(XLEN+4))-1:0]      o_rdata,
  output logic                          o_rdata_valid,
  output logic                          o_misaligned_load,
  output logic                          o_misaligned_store,
  output logic                          o_access_fault_load,
  output logic                          o_access_fault_store,
  output logic                          o_bus_req,
  output logic                          o_bus_we,
  output logic [(1<<(XLEN+4))-1:0]      o_bus_addr,
  output logic [(1<<(XLEN+4))-1:0]      o_bus_wdata,
  output logic [(1<<(XLEN+1))-1:0]      o_bus_be,
  input  logic                          i_bus_ack,
  input  logic [(1<<(XLEN+4))-1:0]      i_bus_rdata
);

  localparam int unsigned W  = 1 << (XLEN + 4);
  localparam int unsigned B  = W / 8;
  localparam int unsigned LB = $clog2(B);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
`ifdef IO_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  // Extend a lane-aligned load from its access size; funct3[2] selects zero-extension.
  function automatic logic [W-1:0] load_ext(input logic [W-1:0] raw, input logic [2:0] f3);
    logic [W-1:0] keep;
    logic         sbit;
    case (f3[1:0])
      2'd0:    begin keep = W'(8'hFF);         sbit = raw[7];   end
      2'd1:    begin keep = W'(16'hFFFF);      sbit = raw[15];  end
      2'd2:    begin keep = W'(32'hFFFF_FFFF); sbit = raw[31];  end
      default: begin keep = '1;                sbit = raw[W-1]; end
    endcase
    return (raw & keep) | (~keep & {W{sbit & ~f3[2]}});
  endfunction

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [LB-1:0]   k_q, k_d;
  logic [W-1:0]    addr_q, addr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [B-1:0]    be_q, be_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            rdata_valid_q, rdata_valid_d;

  logic            access;
  logic            mis_addr;
  logic            bad_size;
  logic            misaligned;
  logic            start;
  logic [LB-1:0]   k_in;
  logic [B-1:0]    lane_mask;

  assign access = i_io_en_m & (i_lw_m | i_sw_m);
  assign k_in   = i_addr_m[LB-1:0];

  always_comb begin
    mis_addr  = 1'b0;
    lane_mask = '0;
    case (i_funct3_m[1:0])
      2'd0:    begin mis_addr = 1'b0;           lane_mask = B'(4'h1); end
      2'd1:    begin mis_addr = i_addr_m[0];    lane_mask = B'(4'h3); end
      2'd2:    begin mis_addr = |i_addr_m[1:0]; lane_mask = B'(4'hF); end
      default: begin mis_addr = |i_addr_m[2:0]; lane_mask = '1;       end
    endcase
  end

  // Doubleword and word-unsigned accesses do not exist on a 32-bit bus.
  assign bad_size   = (XLEN == 1) && ((i_funct3_m[1:0] == 2'd3) || (i_funct3_m == 3'd6));
  assign misaligned = mis_addr | bad_size;
  assign start      = access & ~misaligned;

  assign o_misaligned_load  = access & misaligned & i_lw_m;
  assign o_misaligned_store = access & misaligned & i_sw_m;

  // The stall rises in the detect cycle, before the FSM has left IDLE.
  assign o_stall   = ((state_q == S_IDLE) & start) | (state_q == S_REQ);
  assign o_bus_req = (state_q == S_REQ);

  assign o_bus_we      = we_q;
  assign o_bus_addr    = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_be      = be_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;

`ifdef IO_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       flt_ld_q, flt_ld_d;
  logic       flt_st_q, flt_st_d;
  logic       timeout_hit;

  // Counter holds the number of REQ cycles already spent; the current cycle is the last allowed.
  assign timeout_hit = (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES));

  assign o_access_fault_load  = flt_ld_q;
  assign o_access_fault_store = flt_st_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;

  assign o_access_fault_load  = 1'b0;
  assign o_access_fault_store = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    f3_d          = f3_q;
    k_d           = k_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
`ifdef IO_TIMEOUT_EN
    cnt_d         = cnt_q;
    flt_ld_d      = 1'b0;
    flt_st_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          we_d    = i_sw_m;
          f3_d    = i_funct3_m;
          k_d     = k_in;
          addr_d  = {i_addr_m[W-1:LB], {LB{1'b0}}};
          wdata_d = i_wdata_m << {k_in, 3'b000};
          be_d    = lane_mask << k_in;
`ifdef IO_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_REQ: begin
`ifdef IO_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // An ack in the final allowed cycle still completes the access.
        if (i_bus_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d       = load_ext(i_bus_rdata >> {k_q, 3'b000}, f3_q);
            rdata_valid_d = 1'b1;
          end
        end
`ifdef IO_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d  = S_FAULT;
          rdata_d  = '0;
          flt_ld_d = ~we_q;
          flt_st_d = we_q;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef IO_TIMEOUT_EN
      S_FAULT: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'd0;
      k_q           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
`ifdef IO_TIMEOUT_EN
      cnt_q         <= 8'd0;
      flt_ld_q      <= 1'b0;
      flt_st_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      f3_q          <= f3_d;
      k_q           <= k_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
`ifdef IO_TIMEOUT_EN
      cnt_q         <= cnt_d;
      flt_ld_q      <= flt_ld_d;
      flt_st_q      <= flt_st_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge (XLEN 64, TIMEOUT_CYCLES 4).
// Stimulus pushes expected bus handshakes, load results, faults, misalignment
// flags and stall-run lengths; a negedge monitor pops and compares them.
module tb_io_bus_bridge;
  localparam int W  = 64;
  localparam int B  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         io_en, lw, sw;
  logic [2:0]   f3;
  logic [W-1:0] addr, wdata, bus_rdata;
  logic         ack;

  logic         o_stall, o_rdata_valid;
  logic [W-1:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic         o_mis_ld, o_mis_st, o_flt_ld, o_flt_st;
  logic         o_bus_req, o_bus_we;
  logic [B-1:0] o_bus_be;

  always #5 clk = ~clk;

  io_bus_bridge #(.XLEN(2), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_io_en_m(io_en), .i_lw_m(lw), .i_sw_m(sw),
    .i_funct3_m(f3), .i_addr_m(addr), .i_wdata_m(wdata),
    .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_misaligned_load(o_mis_ld), .o_misaligned_store(o_mis_st),
    .o_access_fault_load(o_flt_ld), .o_access_fault_store(o_flt_st),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_ack(ack), .i_bus_rdata(bus_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [63:0] rd_q[$];
  logic [1:0]  flt_q[$];
  logic [1:0]  mis_q[$];
  int          stl_q[$];

  int          checks = 0;
  int          errors = 0;
  int          stall_run = 0;
  bit          mon_en = 1'b0;
  logic [63:0] last_rd = 64'h0;
  bus_t        bus_e;
  logic [63:0] rd_e;
  logic [1:0]  flag_e;
  int          stl_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic exp_bus(input logic we, input logic [63:0] a, input logic [7:0] be,
                         input logic [63:0] wd);
    bus_t e;
    e.we = we; e.addr = a; e.be = be; e.wdata = wd;
    bus_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_bus_req && ack) begin
        if (bus_q.size() == 0) unexpected("bus_handshake");
        else begin
          bus_e = bus_q.pop_front();
          chk("bus_we", {63'd0, o_bus_we}, {63'd0, bus_e.we});
          chk("bus_addr", o_bus_addr, bus_e.addr);
          chk("bus_be", {56'd0, o_bus_be}, {56'd0, bus_e.be});
          chk("bus_wdata", o_bus_wdata, bus_e.wdata);
        end
      end
      if (o_rdata_valid) begin
        if (rd_q.size() == 0) unexpected("rdata_valid");
        else begin
          rd_e = rd_q.pop_front();
          chk("rdata", o_rdata, rd_e);
        end
      end
      if (o_flt_ld || o_flt_st) begin
        if (flt_q.size() == 0) unexpected("access_fault");
        else begin
          flag_e = flt_q.pop_front();
          chk("fault_flags", {62'd0, o_flt_ld, o_flt_st}, {62'd0, flag_e});
          chk("fault_rdata_zero", o_rdata, 64'd0);
          chk("fault_req_low", {63'd0, o_bus_req}, 64'd0);
          chk("fault_stall_low", {63'd0, o_stall}, 64'd0);
        end
      end
      if (o_mis_ld || o_mis_st) begin
        if (mis_q.size() == 0) unexpected("misaligned");
        else begin
          flag_e = mis_q.pop_front();
          chk("mis_flags", {62'd0, o_mis_ld, o_mis_st}, {62'd0, flag_e});
          chk("mis_stall_low", {63'd0, o_stall}, 64'd0);
          chk("mis_req_low", {63'd0, o_bus_req}, 64'd0);
        end
      end
      if (o_stall) stall_run++;
      else if (stall_run > 0) begin
        if (stl_q.size() == 0) unexpected("stall_run");
        else begin
          stl_e = stl_q.pop_front();
          chk("stall_cycles", 64'(stall_run), 64'(stl_e));
        end
        stall_run = 0;
      end
    end
  end

  // One aligned access; ack in REQ cycle ack_at, at most max_req REQ cycles.
  task automatic do_access(input logic l, input logic s, input logic [2:0] fn,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rd, input int ack_at, input int max_req);
    @(posedge clk); #1;
    io_en = 1'b1; lw = l; sw = s; f3 = fn; addr = a; wdata = wd;
    @(posedge clk); #1;
    for (int j = 1; j <= max_req; j++) begin
      ack       = (j == ack_at);
      bus_rdata = (j == ack_at) ? rd : 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk); #1;
      if (j == ack_at) break;
    end
    ack = 1'b0;
    @(posedge clk); #1;
    io_en = 1'b0; lw = 1'b0; sw = 1'b0;
  endtask

  task automatic do_misaligned(input logic l, input logic s, input logic [2:0] fn,
                               input logic [63:0] a);
    @(posedge clk); #1;
    io_en = 1'b1; lw = l; sw = s; f3 = fn; addr = a; wdata = 64'hFFFF;
    @(posedge clk); #1;
    io_en = 1'b0; lw = 1'b0; sw = 1'b0;
    @(negedge clk);
    chk("mis_no_req_after", {63'd0, o_bus_req}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; io_en = 1'b0; lw = 1'b0; sw = 1'b0; f3 = 3'd0;
    addr = '0; wdata = '0; bus_rdata = '0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_ctrl", {56'd0, o_rdata_valid, o_mis_ld, o_mis_st, o_flt_ld, o_flt_st,
                     o_bus_req, o_bus_we, 1'b0}, 64'd0);
    chk("rst_bus_addr", o_bus_addr, 64'd0);
    chk("rst_bus_wdata", o_bus_wdata, 64'd0);
    chk("rst_bus_be", {56'd0, o_bus_be}, 64'd0);
    mon_en = 1'b1;

    // lw at 0x14: lane 4 holds 0xFFFF_FFF0
    exp_bus(1'b0, 64'h10, 8'hF0, 64'h0);
    rd_q.push_back(64'hFFFF_FFFF_FFFF_FFF0); stl_q.push_back(2);
    do_access(1'b1, 1'b0, 3'd2, 64'h14, 64'h0, 64'hFFFF_FFF0_1234_5678, 1, 1);
    last_rd = 64'hFFFF_FFFF_FFFF_FFF0;

    // sb at 0x3, ack in the 4th REQ cycle
    exp_bus(1'b1, 64'h0, 8'h08, 64'h0000_0000_AB00_0000);
    stl_q.push_back(5);
    do_access(1'b0, 1'b1, 3'd0, 64'h3, 64'hAB, 64'h0, 4, 4);
    @(negedge clk);
    chk("rdata_hold_after_store", o_rdata, last_rd);

    // lh at 0x6, sign-extends 0x8001
    exp_bus(1'b0, 64'h0, 8'hC0, 64'h0);
    rd_q.push_back(64'hFFFF_FFFF_FFFF_8001); stl_q.push_back(3);
    do_access(1'b1, 1'b0, 3'd1, 64'h6, 64'h0, 64'h8001_5555_5555_5555, 2, 2);

    // ld at 0x8
    exp_bus(1'b0, 64'h8, 8'hFF, 64'h0);
    rd_q.push_back(64'h0123_4567_89AB_CDEF); stl_q.push_back(2);
    do_access(1'b1, 1'b0, 3'd3, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1);

    // lwu at 0x24 zero-extends 0x8000_0000
    exp_bus(1'b0, 64'h20, 8'hF0, 64'h0);
    rd_q.push_back(64'h0000_0000_8000_0000); stl_q.push_back(2);
    do_access(1'b1, 1'b0, 3'd6, 64'h24, 64'h0, 64'h8000_0000_DEAD_BEEF, 1, 1);
    last_rd = 64'h0000_0000_8000_0000;

    // sh at 0x2
    exp_bus(1'b1, 64'h0, 8'h0C, 64'h0000_0000_1234_0000);
    stl_q.push_back(2);
    do_access(1'b0, 1'b1, 3'd1, 64'h2, 64'h1234, 64'h0, 1, 1);

    // misaligned: lh at 0x1, sw at 0x2, ld at 0x4
    mis_q.push_back(2'b10);
    do_misaligned(1'b1, 1'b0, 3'd1, 64'h1);
    mis_q.push_back(2'b01);
    do_misaligned(1'b0, 1'b1, 3'd2, 64'h2);
    mis_q.push_back(2'b10);
    do_misaligned(1'b1, 1'b0, 3'd3, 64'h4);

`ifdef IO_TIMEOUT_EN
    // sw with no ack: 4 REQ cycles then a store fault
    flt_q.push_back(2'b01); stl_q.push_back(5);
    do_access(1'b0, 1'b1, 3'd2, 64'h1C, 64'hCAFE_BABE, 64'h0, 0, TO);
    // lw with no ack: load fault
    flt_q.push_back(2'b10); stl_q.push_back(5);
    do_access(1'b1, 1'b0, 3'd2, 64'h0, 64'h0, 64'h0, 0, TO);
`else
    // without the timeout, a long wait still completes on ack
    exp_bus(1'b1, 64'h18, 8'hF0, 64'hCAFE_BABE_0000_0000);
    stl_q.push_back(10);
    do_access(1'b0, 1'b1, 3'd2, 64'h1C, 64'hCAFE_BABE, 64'h0, 9, 9);
`endif

    // lbu with ack in the 4th REQ cycle (coincides with the timeout cycle)
    exp_bus(1'b0, 64'h0, 8'h01, 64'h0);
    rd_q.push_back(64'h80); stl_q.push_back(5);
    do_access(1'b1, 1'b0, 3'd4, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 4, 4);

    // reset during the 2nd REQ cycle of a sw, then a late ack
    stl_q.push_back(3);
    @(posedge clk); #1;
    io_en = 1'b1; sw = 1'b1; f3 = 3'd2; addr = 64'h2C; wdata = 64'h5A5A_5A5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; io_en = 1'b0; sw = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ack = 1'b1; bus_rdata = '1;
    @(negedge clk);
    chk("rst_req_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_req_ctrl", {58'd0, o_bus_req, o_bus_we, o_rdata_valid, o_flt_ld, o_flt_st,
                         o_mis_st}, 64'd0);
    chk("rst_req_addr", o_bus_addr, 64'd0);
    chk("rst_req_wdata", o_bus_wdata, 64'd0);
    chk("rst_req_be", {56'd0, o_bus_be}, 64'd0);
    chk("rst_req_rdata", o_rdata, 64'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", {61'd0, o_bus_req, o_rdata_valid, o_stall}, 64'd0);

    // lb at 0x5 after reset: lane 5 = 0x7F
    exp_bus(1'b0, 64'h0, 8'h20, 64'h0);
    rd_q.push_back(64'h7F); stl_q.push_back(2);
    do_access(1'b1, 1'b0, 3'd0, 64'h5, 64'h0, 64'h0000_7F00_0000_0000, 1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", 64'(bus_q.size() + rd_q.size() + flt_q.size() + mis_q.size() +
                              stl_q.size() + stall_run), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
